// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - microcode sequencer: T-state counter and 16-bit control word
module control_sequencer #(
    parameter int STEPS     = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  opcode,
    input  logic        flag_c,
    input  logic        flag_z,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted
);
    // control word bit positions, bit15..bit0
    localparam logic [15:0] HLT = 16'h8000;
    localparam logic [15:0] MI  = 16'h4000;
    localparam logic [15:0] RI  = 16'h2000;
    localparam logic [15:0] RO  = 16'h1000;
    localparam logic [15:0] IO  = 16'h0800;
    localparam logic [15:0] II  = 16'h0400;
    localparam logic [15:0] AI  = 16'h0200;
    localparam logic [15:0] AO  = 16'h0100;
    localparam logic [15:0] EO  = 16'h0080;
    localparam logic [15:0] SU  = 16'h0040;
    localparam logic [15:0] BI  = 16'h0020;
    localparam logic [15:0] OI  = 16'h0010;
    localparam logic [15:0] CE  = 16'h0008;
    localparam logic [15:0] CO  = 16'h0004;
    localparam logic [15:0] J   = 16'h0002;
    localparam logic [15:0] FI  = 16'h0001;

    localparam logic [3:0] OP_HLT    = 4'b1111;
    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    logic [2:0] step_q, step_d;
    logic       halted_q, halted_d;

    // microcode ROM: control word for a given opcode, T-state and flag pair
    function automatic logic [15:0] microword(input logic [3:0] op, input logic [2:0] s,
                                              input logic c, input logic z);
        logic [15:0] w;
        w = 16'h0000;
        if (s == 3'd0) begin
            w = CO | MI;
        end else if (s == 3'd1) begin
            w = RO | II | CE;
        end else begin
            case (op)
                4'b0001: if (s == 3'd2) w = IO | MI; else if (s == 3'd3) w = RO | AI;
                4'b0010: if (s == 3'd2) w = IO | MI; else if (s == 3'd3) w = RO | BI;
                         else if (s == 3'd4) w = EO | AI | FI;
                4'b0011: if (s == 3'd2) w = IO | MI; else if (s == 3'd3) w = RO | BI;
                         else if (s == 3'd4) w = EO | AI | SU | FI;
                4'b0100: if (s == 3'd2) w = IO | MI; else if (s == 3'd3) w = AO | RI;
                4'b0101: if (s == 3'd2) w = IO | AI;
                4'b0110: if (s == 3'd2) w = IO | J;
                4'b0111: if (s == 3'd2 && c) w = IO | J;
                4'b1000: if (s == 3'd2 && z) w = IO | J;
                4'b1110: if (s == 3'd2) w = AO | OI;
                4'b1111: if (s == 3'd2) w = HLT;
                default: w = 16'h0000;
            endcase
        end
        return w;
    endfunction

    // state register: step counter and halt latch
    always_ff @(posedge clk) begin
        if (clr) begin
            step_q   <= 3'd0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    // next step / halt decision; T0 and T1 never decide because opcode is stale in T1
    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (step_q == 3'd0) begin
                step_d = 3'd1;
            end else if (step_q == 3'd1) begin
                step_d = 3'd2;
            end else if (step_q == 3'd2 && opcode == OP_HLT) begin
                halted_d = 1'b1;
            end else if (step_q >= LAST_STEP) begin
                step_d = 3'd0;
            end else if (EARLY_END && microword(opcode, 3'(step_q + 3'd1), flag_c, flag_z) == 16'h0000) begin
                step_d = 3'd0;
            end else begin
                step_d = 3'(step_q + 3'd1);
            end
        end
    end

    // control word: suppressed during reset, pinned to hlt while halted
    always_comb begin
        ctrl = 16'h0000;
        if (clr)
            ctrl = 16'h0000;
        else if (halted_q)
            ctrl = HLT;
        else
            ctrl = microword(opcode, step_q, flag_c, flag_z);
    end

    assign step   = step_q;
    assign halted = halted_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - scoreboard bench for control_sequencer
module tb_control_sequencer;
    logic        clk = 1'b0;
    logic        clr_a, clr_b;
    logic [3:0]  opcode_a, opcode_b;
    logic        fc_a, fz_a, fc_b, fz_b;
    logic [15:0] ctrl_a, ctrl_b;
    logic [2:0]  step_a, step_b;
    logic        halted_a, halted_b;

    int errors = 0;
    int checks = 0;
    int next_id = 0;

    typedef struct {
        bit          sel;
        logic [15:0] c;
        logic [2:0]  s;
        logic        h;
        int          id;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    control_sequencer #(.STEPS(5), .EARLY_END(1'b1)) dut_a (
        .clk(clk), .clr(clr_a), .opcode(opcode_a), .flag_c(fc_a), .flag_z(fz_a),
        .ctrl(ctrl_a), .step(step_a), .halted(halted_a)
    );

    control_sequencer #(.STEPS(5), .EARLY_END(1'b0)) dut_b (
        .clk(clk), .clr(clr_b), .opcode(opcode_b), .flag_c(fc_b), .flag_z(fz_b),
        .ctrl(ctrl_b), .step(step_b), .halted(halted_b)
    );

    // monitor: on every falling edge pop one expectation and compare
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [15:0] ac;
            logic [2:0]  as;
            logic        ah;
            e  = sb.pop_front();
            ac = e.sel ? ctrl_b : ctrl_a;
            as = e.sel ? step_b : step_a;
            ah = e.sel ? halted_b : halted_a;
            checks = checks + 1;
            if (ac !== e.c || as !== e.s || ah !== e.h) begin
                errors = errors + 1;
                $display("FAIL chk%0d dut_%s: got ctrl=%h step=%0d halted=%b, want ctrl=%h step=%0d halted=%b",
                         e.id, e.sel ? "b" : "a", ac, as, ah, e.c, e.s, e.h);
            end
        end
    end

    // push the expected outputs for the current cycle, then advance one clock
    task automatic cyc(input bit sel, input logic [15:0] c, input logic [2:0] s, input logic h);
        exp_t e;
        e.sel = sel; e.c = c; e.s = s; e.h = h; e.id = next_id;
        next_id = next_id + 1;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_a(input logic [3:0] op);
        cyc(0, 16'h4004, 3'd0, 1'b0);
        opcode_a = op;
        cyc(0, 16'h1408, 3'd1, 1'b0);
    endtask

    initial begin
        clr_a = 1'b1; opcode_a = 4'b0010; fc_a = 1'b0; fz_a = 1'b0;
        clr_b = 1'b1; opcode_b = 4'b0000; fc_b = 1'b0; fz_b = 1'b0;
        @(posedge clk);
        #1;
        // reset held two cycles with ADD on the opcode bus
        cyc(0, 16'h0000, 3'd0, 1'b0);
        cyc(0, 16'h0000, 3'd0, 1'b0);
        clr_a = 1'b0;
        // ADD full loop
        fetch_a(4'b0010);
        cyc(0, 16'h4800, 3'd2, 1'b0);
        cyc(0, 16'h1020, 3'd3, 1'b0);
        cyc(0, 16'h0281, 3'd4, 1'b0);
        // JC taken
        fc_a = 1'b1;
        fetch_a(4'b0111);
        cyc(0, 16'h0802, 3'd2, 1'b0);
        // JC not taken: 3-cycle instruction
        fc_a = 1'b0;
        fetch_a(4'b0111);
        cyc(0, 16'h0000, 3'd2, 1'b0);
        // JZ taken
        fz_a = 1'b1;
        fetch_a(4'b1000);
        cyc(0, 16'h0802, 3'd2, 1'b0);
        fz_a = 1'b0;
        // LDA, STA, LDI, OUT, undefined
        fetch_a(4'b0001);
        cyc(0, 16'h4800, 3'd2, 1'b0);
        cyc(0, 16'h1200, 3'd3, 1'b0);
        fetch_a(4'b0100);
        cyc(0, 16'h4800, 3'd2, 1'b0);
        cyc(0, 16'h2100, 3'd3, 1'b0);
        fetch_a(4'b0101);
        cyc(0, 16'h0A00, 3'd2, 1'b0);
        fetch_a(4'b1110);
        cyc(0, 16'h0110, 3'd2, 1'b0);
        fetch_a(4'b1010);
        cyc(0, 16'h0000, 3'd2, 1'b0);
        // SUB full loop
        fetch_a(4'b0011);
        cyc(0, 16'h4800, 3'd2, 1'b0);
        cyc(0, 16'h1020, 3'd3, 1'b0);
        cyc(0, 16'h02C1, 3'd4, 1'b0);
        // SUB abandoned by clr during T3
        fetch_a(4'b0011);
        cyc(0, 16'h4800, 3'd2, 1'b0);
        clr_a = 1'b1;
        cyc(0, 16'h0000, 3'd3, 1'b0);
        clr_a = 1'b0;
        cyc(0, 16'h4004, 3'd0, 1'b0);
        cyc(0, 16'h1408, 3'd1, 1'b0);
        cyc(0, 16'h4800, 3'd2, 1'b0);
        cyc(0, 16'h1020, 3'd3, 1'b0);
        cyc(0, 16'h02C1, 3'd4, 1'b0);
        // HLT, then ten cycles of noise on opcode/flags
        fetch_a(4'b1111);
        cyc(0, 16'h8000, 3'd2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            opcode_a = 4'(i);
            fc_a = i[0];
            fz_a = i[1];
            cyc(0, 16'h8000, 3'd2, 1'b1);
        end
        // only clr leaves halt
        opcode_a = 4'b0000;
        clr_a = 1'b1;
        cyc(0, 16'h0000, 3'd2, 1'b1);
        clr_a = 1'b0;
        cyc(0, 16'h4004, 3'd0, 1'b0);

        // fixed-length instance: NOP and LDA both take 5 cycles
        cyc(1, 16'h0000, 3'd0, 1'b0);
        clr_b = 1'b0;
        cyc(1, 16'h4004, 3'd0, 1'b0);
        cyc(1, 16'h1408, 3'd1, 1'b0);
        cyc(1, 16'h0000, 3'd2, 1'b0);
        cyc(1, 16'h0000, 3'd3, 1'b0);
        cyc(1, 16'h0000, 3'd4, 1'b0);
        cyc(1, 16'h4004, 3'd0, 1'b0);
        opcode_b = 4'b0001;
        cyc(1, 16'h1408, 3'd1, 1'b0);
        cyc(1, 16'h4800, 3'd2, 1'b0);
        cyc(1, 16'h1200, 3'd3, 1'b0);
        cyc(1, 16'h0000, 3'd4, 1'b0);
        cyc(1, 16'h4004, 3'd0, 1'b0);

        // every pushed expectation must have been consumed by the monitor
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
